// File: rtl/reg_alias_table.sv
// Register alias table: combinational rename lookup, 1-cycle registered frees, RUN/RECOVER rollback FSM.
// Renames stall (rename_ready=0) during recovery or when the free list is empty; commits stall while recovering.
module reg_alias_table #(
  parameter int REG_FILE_ADDR_WIDTH = 7,
  parameter int ARCH_REGS           = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           rename_valid,
  input  logic [4:0]                     rename_rd,
  input  logic [4:0]                     rename_rs1,
  input  logic [4:0]                     rename_rs2,
  output logic                           rename_ready,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rename_prs1,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rename_prs2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rename_prd,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rename_old_prd,
  output logic                           free_list_take,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] free_list_reg,
  input  logic                           free_list_empty,
  input  logic                           commit_valid,
  input  logic [4:0]                     commit_rd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] commit_old_prd,
  output logic                           commit_ready,
  input  logic                           flush_start,
  input  logic                           flush_done,
  input  logic                           rollback_valid,
  input  logic [4:0]                     rollback_rd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rollback_prd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rollback_old_prd,
  output logic                           reg_freed,
  output logic [REG_FILE_ADDR_WIDTH-1:0] freed_reg_num,
  output logic                           recovering,
  output logic [REG_FILE_ADDR_WIDTH-1:0] inflight_count
);

  localparam int W = REG_FILE_ADDR_WIDTH;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   map_q [ARCH_REGS];
  logic           commit_acc;
  logic           rollback_acc;
  logic           rollback_wr;
  logic           inflight_inc;
  logic           inflight_dec;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    rename_ready = 1'b0;
    commit_ready = 1'b0;
    recovering   = 1'b0;
    case (state)
      RUN: begin
        commit_ready = 1'b1;
        rename_ready = !flush_start && (!free_list_empty || rename_rd == 5'd0);
        if (flush_start) state_next = RECOVER;
      end
      RECOVER: begin
        recovering = 1'b1;
        if (flush_done) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Lookups see the table before this cycle's write, so rs == rd yields the old mapping.
  assign rename_prs1    = (rename_rs1 == 5'd0) ? '0 : map_q[rename_rs1];
  assign rename_prs2    = (rename_rs2 == 5'd0) ? '0 : map_q[rename_rs2];
  assign rename_old_prd = (rename_rd  == 5'd0) ? '0 : map_q[rename_rd];
  assign rename_prd     = (rename_rd  == 5'd0) ? '0 : free_list_reg;
  assign free_list_take = rename_valid && rename_ready && (rename_rd != 5'd0);

  assign commit_acc   = commit_valid && commit_ready;
  assign rollback_acc = rollback_valid && recovering;
  assign rollback_wr  = rollback_acc && (rollback_rd != 5'd0);

  // Rename writes only in RUN, rollback only in RECOVER, so the two never collide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= W'(i);
    end else begin
      if (free_list_take) map_q[rename_rd] <= free_list_reg;
      if (rollback_wr)    map_q[rollback_rd] <= rollback_old_prd;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_freed     <= 1'b0;
      freed_reg_num <= '0;
    end else if (commit_acc && commit_old_prd != '0) begin
      reg_freed     <= 1'b1;
      freed_reg_num <= commit_old_prd;
    end else if (rollback_acc && rollback_prd != '0) begin
      reg_freed     <= 1'b1;
      freed_reg_num <= rollback_prd;
    end else begin
      reg_freed     <= 1'b0;
      freed_reg_num <= '0;
    end
  end

  assign inflight_inc = free_list_take;
  assign inflight_dec = (commit_acc && commit_rd != 5'd0) || rollback_wr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_count <= '0;
    end else if (inflight_inc && !inflight_dec) begin
      if (inflight_count != {W{1'b1}}) inflight_count <= inflight_count + W'(1);
    end else if (inflight_dec && !inflight_inc) begin
      if (inflight_count != '0) inflight_count <= inflight_count - W'(1);
    end
  end

endmodule

// File: tb/tb_reg_alias_table.sv
// Bench for reg_alias_table: directed literal scenarios plus randomized traffic against an array/flag model.
module tb_reg_alias_table;
  localparam int W = 7;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         rename_valid;
  logic [4:0]   rename_rd, rename_rs1, rename_rs2;
  logic         rename_ready;
  logic [W-1:0] rename_prs1, rename_prs2, rename_prd, rename_old_prd;
  logic         free_list_take;
  logic [W-1:0] free_list_reg;
  logic         free_list_empty;
  logic         commit_valid;
  logic [4:0]   commit_rd;
  logic [W-1:0] commit_old_prd;
  logic         commit_ready;
  logic         flush_start, flush_done;
  logic         rollback_valid;
  logic [4:0]   rollback_rd;
  logic [W-1:0] rollback_prd, rollback_old_prd;
  logic         reg_freed;
  logic [W-1:0] freed_reg_num;
  logic         recovering;
  logic [W-1:0] inflight_count;

  reg_alias_table #(.REG_FILE_ADDR_WIDTH(W), .ARCH_REGS(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .rename_valid(rename_valid), .rename_rd(rename_rd), .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
    .rename_ready(rename_ready), .rename_prs1(rename_prs1), .rename_prs2(rename_prs2),
    .rename_prd(rename_prd), .rename_old_prd(rename_old_prd),
    .free_list_take(free_list_take), .free_list_reg(free_list_reg), .free_list_empty(free_list_empty),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_old_prd(commit_old_prd),
    .commit_ready(commit_ready), .flush_start(flush_start), .flush_done(flush_done),
    .rollback_valid(rollback_valid), .rollback_rd(rollback_rd), .rollback_prd(rollback_prd),
    .rollback_old_prd(rollback_old_prd), .reg_freed(reg_freed), .freed_reg_num(freed_reg_num),
    .recovering(recovering), .inflight_count(inflight_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: architectural map, recovery flag, the free announced this cycle, in-flight renames.
  int m_map[32];
  bit m_rec;
  bit m_fv;
  int m_fn;
  int m_inf;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    m_rec = 0; m_fv = 0; m_fn = 0; m_inf = 0;
  endtask

  task automatic idle();
    rename_valid = 0; rename_rd = 0; rename_rs1 = 0; rename_rs2 = 0;
    free_list_reg = 0; free_list_empty = 0;
    commit_valid = 0; commit_rd = 0; commit_old_prd = 0;
    flush_start = 0; flush_done = 0;
    rollback_valid = 0; rollback_rd = 0; rollback_prd = 0; rollback_old_prd = 0;
  endtask

  function automatic bit exp_ready();
    return !m_rec && !flush_start && (!free_list_empty || rename_rd == 0);
  endfunction

  // Compare every output against the model; called late in the cycle, well before the next rising edge.
  task automatic settle();
    bit rdy;
    #3;
    rdy = exp_ready();
    check("rename_ready", int'(rename_ready), int'(rdy));
    check("free_list_take", int'(free_list_take), int'(rename_valid && rdy && rename_rd != 0));
    check("commit_ready", int'(commit_ready), int'(!m_rec));
    check("recovering", int'(recovering), int'(m_rec));
    check("prs1", int'(rename_prs1), m_map[rename_rs1]);
    check("prs2", int'(rename_prs2), m_map[rename_rs2]);
    check("reg_freed", int'(reg_freed), int'(m_fv));
    if (m_fv) check("freed_reg_num", int'(freed_reg_num), m_fn);
    check("inflight_count", int'(inflight_count), m_inf);
    if (rename_valid && rdy) begin
      check("prd", int'(rename_prd), (rename_rd == 0) ? 0 : int'(free_list_reg));
      check("old_prd", int'(rename_old_prd), m_map[rename_rd]);
    end
  endtask

  // Advance one clock and apply the rules to the model using the inputs held across the edge.
  task automatic tick();
    bit take, cacc, racc;
    take = rename_valid && exp_ready() && rename_rd != 0;
    cacc = commit_valid && !m_rec;
    racc = rollback_valid && m_rec;
    @(posedge clock);
    if (cacc && commit_old_prd != 0) begin m_fv = 1; m_fn = commit_old_prd; end
    else if (racc && rollback_prd != 0) begin m_fv = 1; m_fn = rollback_prd; end
    else m_fv = 0;
    if (take) m_map[rename_rd] = free_list_reg;
    if (racc && rollback_rd != 0) m_map[rollback_rd] = rollback_old_prd;
    m_inf = m_inf + int'(take) - int'(cacc && commit_rd != 0) - int'(racc && rollback_rd != 0);
    if (m_inf < 0) m_inf = 0;
    if (m_inf > 127) m_inf = 127;
    if (!m_rec && flush_start) m_rec = 1;
    else if (m_rec && flush_done) m_rec = 0;
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    #2;
    reset_n = 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 0;
    #12 reset_n = 1;
    @(posedge clock); #1;

    // Reset state
    rename_rs1 = 5; rename_rs2 = 0;
    settle();
    check("lit_rst_prs1", int'(rename_prs1), 5);
    check("lit_rst_prs2", int'(rename_prs2), 0);
    check("lit_rst_freed", int'(reg_freed), 0);
    check("lit_rst_inflight", int'(inflight_count), 0);
    tick();

    // Empty free list blocks rd!=0 but not rd==0
    idle(); free_list_empty = 1; rename_valid = 1; rename_rd = 4; free_list_reg = 50;
    settle();
    check("lit_empty_ready", int'(rename_ready), 0);
    check("lit_empty_take", int'(free_list_take), 0);
    tick();
    idle(); free_list_empty = 1; rename_valid = 1; rename_rd = 0; rename_rs1 = 4;
    settle();
    check("lit_rd0_ready", int'(rename_ready), 1);
    check("lit_rd0_prd", int'(rename_prd), 0);
    check("lit_map4_unchanged", int'(rename_prs1), 4);
    tick();

    // Rename rd=3 -> p32, then commit rd=3 old_prd=3
    idle(); rename_valid = 1; rename_rd = 3; rename_rs1 = 3; free_list_reg = 32;
    settle();
    check("lit_take", int'(free_list_take), 1);
    check("lit_prd", int'(rename_prd), 32);
    check("lit_old_prd", int'(rename_old_prd), 3);
    check("lit_rs_eq_rd_old", int'(rename_prs1), 3);
    tick();
    idle(); rename_rs1 = 3;
    settle();
    check("lit_prs1_new", int'(rename_prs1), 32);
    check("lit_inflight1", int'(inflight_count), 1);
    tick();
    idle(); commit_valid = 1; commit_rd = 3; commit_old_prd = 3;
    cycle();
    idle();
    settle();
    check("lit_commit_freed", int'(reg_freed), 1);
    check("lit_commit_num", int'(freed_reg_num), 3);
    check("lit_commit_inflight", int'(inflight_count), 0);
    tick();
    idle();
    settle();
    check("lit_freed_drop", int'(reg_freed), 0);
    tick();

    // Fresh start, rename rd=3 -> p32, then flush and roll it back
    idle(); do_reset();
    idle(); rename_valid = 1; rename_rd = 3; free_list_reg = 32;
    cycle();
    idle(); flush_start = 1; rename_valid = 1; rename_rd = 1; free_list_reg = 40;
    settle();
    check("lit_fs_ready", int'(rename_ready), 0);
    tick();
    idle(); rollback_valid = 1; rollback_rd = 3; rollback_prd = 32; rollback_old_prd = 3;
    rename_valid = 1; rename_rd = 1; free_list_reg = 40; commit_valid = 1; commit_rd = 2; commit_old_prd = 9;
    settle();
    check("lit_rec_ready", int'(rename_ready), 0);
    check("lit_rec_cready", int'(commit_ready), 0);
    check("lit_rec_flag", int'(recovering), 1);
    tick();
    idle(); rename_rs1 = 3; flush_start = 1;
    settle();
    check("lit_rb_map3", int'(rename_prs1), 3);
    check("lit_rb_freed", int'(reg_freed), 1);
    check("lit_rb_num", int'(freed_reg_num), 32);
    check("lit_rb_cready", int'(commit_ready), 0);
    tick();
    idle(); flush_done = 1;
    cycle();
    idle();
    settle();
    check("lit_run_ready", int'(rename_ready), 1);
    check("lit_run_cready", int'(commit_ready), 1);
    tick();

    // Reset during recovery with a free in flight
    idle(); rename_valid = 1; rename_rd = 7; free_list_reg = 40;
    cycle();
    idle(); flush_start = 1;
    cycle();
    idle(); rollback_valid = 1; rollback_rd = 7; rollback_prd = 40; rollback_old_prd = 7;
    cycle();
    idle(); rename_rs1 = 7; rename_rs2 = 3;
    #1;
    check("lit_pre_rst_freed", int'(reg_freed), 1);
    reset_n = 0;
    #1;
    check("lit_arst_rec", int'(recovering), 0);
    check("lit_arst_freed", int'(reg_freed), 0);
    check("lit_arst_map7", int'(rename_prs1), 7);
    check("lit_arst_map3", int'(rename_prs2), 3);
    check("lit_arst_inflight", int'(inflight_count), 0);
    model_reset();
    #1 reset_n = 1;
    @(posedge clock); #1;
    settle();
    check("lit_post_rst_freed", int'(reg_freed), 0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      idle();
      rename_valid = ($urandom_range(0, 3) != 0);
      rename_rd = 5'($urandom_range(0, 31));
      rename_rs1 = 5'($urandom_range(0, 31));
      rename_rs2 = ($urandom_range(0, 3) == 0) ? rename_rd : 5'($urandom_range(0, 31));
      free_list_reg = 7'($urandom_range(32, 127));
      free_list_empty = ($urandom_range(0, 7) == 0) || (m_inf >= 100);
      if (m_inf > 0 && $urandom_range(0, 2) == 0) begin
        commit_valid = 1;
        commit_rd = 5'($urandom_range(1, 31));
        commit_old_prd = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      end
      if ($urandom_range(0, 2) == 0 && (m_inf > 0 || !m_rec)) begin
        rollback_valid = 1;
        rollback_rd = 5'($urandom_range(1, 31));
        rollback_prd = 7'($urandom_range(32, 127));
        rollback_old_prd = 7'($urandom_range(1, 127));
      end
      flush_start = ($urandom_range(0, 24) == 0);
      flush_done = m_rec && ($urandom_range(0, 5) == 0);
      cycle();
    end

    idle();
    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_alias_table.md
REG_ALIAS_TABLE -- requirements
Module: reg_alias_table

Interface
REQ-001 SHALL have parameter REG_FILE_ADDR_WIDTH, default 7, physical register number width.
REQ-002 SHALL have parameter ARCH_REGS, default 32, number of architectural registers (5-bit index).
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rename_valid  input  1  rename request this cycle.
REQ-006 rename_rd / rename_rs1 / rename_rs2  input  5 each  architectural dest/source indices.
REQ-007 rename_ready  output  1  rename accepted when rename_valid && rename_ready.
REQ-008 rename_prs1 / rename_prs2  output  REG_FILE_ADDR_WIDTH each  current mapping of rs1/rs2.
REQ-009 rename_prd / rename_old_prd  output  REG_FILE_ADDR_WIDTH each  new and previous physical reg for rd.
REQ-010 free_list_take  output  1  pops the free list (drives take_next_free).
REQ-011 free_list_reg  input  REG_FILE_ADDR_WIDTH  head of free list (from free_reg_num).
REQ-012 free_list_empty  input  1  free list empty.
REQ-013 commit_valid  input  1; commit_rd  input  5; commit_old_prd  input  REG_FILE_ADDR_WIDTH  retiring instruction.
REQ-014 commit_ready  output  1  commit accepted when commit_valid && commit_ready.
REQ-015 flush_start / flush_done  input  1 each  enter / leave recovery.
REQ-016 rollback_valid  input  1; rollback_rd  input  5; rollback_prd, rollback_old_prd  input  REG_FILE_ADDR_WIDTH  undo one squashed rename (youngest first).
REQ-017 reg_freed  output  1; freed_reg_num  output  REG_FILE_ADDR_WIDTH  return a reg to free list.
REQ-018 recovering  output  1  state == RECOVER.
REQ-019 inflight_count  output  REG_FILE_ADDR_WIDTH  outstanding renames with rd != 0.

Function
REQ-020 SHALL hold map[0..ARCH_REGS-1] of physical numbers; map[0] constant 0, never written.
REQ-021 FSM states RUN, RECOVER; RUN --flush_start--> RECOVER; RECOVER --flush_done--> RUN; flush_start in RECOVER ignored.
REQ-022 rename_prs1/prs2 SHALL be combinational reads of map before any same-cycle update (rs == rd of same instruction returns old mapping).
REQ-023 rename_ready = RUN && !flush_start && (!free_list_empty || rename_rd == 0).
REQ-024 free_list_take = rename_valid && rename_ready && rename_rd != 0, same cycle (zero latency).
REQ-025 On accepted rename with rd != 0: rename_prd = free_list_reg, rename_old_prd = map[rd] (combinational), map[rd] <= free_list_reg at clock edge.
REQ-026 Rename with rd == 0: prd = 0, old_prd = 0, no take, no map write.
REQ-027 commit_ready = (state == RUN); commit does not write map.
REQ-028 Accepted commit with commit_old_prd != 0 SHALL free commit_old_prd: reg_freed = 1, freed_reg_num = commit_old_prd, registered (1 cycle after).
REQ-029 rollback_valid in RECOVER: map[rollback_rd] <= rollback_old_prd (rd != 0); free rollback_prd (registered, 1 cycle); rollback_valid in RUN ignored.
REQ-030 Commit and rollback never concurrent (state-exclusive); at most one free per cycle; reg_freed deasserts when no source.
REQ-031 inflight_count: +1 on rename rd != 0, -1 on commit or rollback with rd != 0; rename+commit same cycle -> unchanged; never wraps (free list bounds it at 2**W - ARCH_REGS).
REQ-032 Rename and commit to same rd same cycle: rename map write applies; commit frees old_prd given by ROB.
REQ-033 flush_done with rollback_valid same cycle: rollback applied, then RUN.

Reset
REQ-034 reset_n low SHALL asynchronously set map[i] = i, state RUN, reg_freed 0, freed_reg_num 0, inflight_count 0, recovering 0.
REQ-035 Reset mid-RECOVER or mid-free SHALL discard pending frees; no reg_freed pulse after release.

Verification
REQ-036 Reset release; rs1=5, rs2=0 -> prs1=5, prs2=0, reg_freed=0, inflight_count=0.
REQ-037 Rename rd=3 with free_list_reg=32 -> take=1 same cycle, prd=32, old_prd=3; next cycle rs1=3 -> prs1=32, inflight_count=1.
REQ-038 Commit rd=3 old_prd=3 -> next cycle reg_freed=1, freed_reg_num=3; inflight_count=0; following cycle reg_freed=0.
REQ-039 free_list_empty=1, rename rd=4 -> rename_ready=0, take=0, map unchanged; rename rd=0 -> accepted, prd=0.
REQ-040 After REQ-037: flush_start, rollback rd=3 prd=32 old_prd=3 -> map[3]=3, next cycle freed_reg_num=32; rename_ready=0, commit_ready=0 until flush_done.
REQ-041 reset_n low during RECOVER with pending free -> immediately recovering=0, reg_freed=0, map identity.
